// File: rtl/sample_step_timer.sv
// ============================================================================
// sample_step_timer
//
// Steps a drum-sample read address at a programmable rate. A trigger starts
// playback. The block then walks the read address from 0 to sample_len-1 and
// emits one addr_valid strobe per sample interval. After the final interval
// it emits a one-cycle done pulse.
//
// The period is sampled only when the countdown is (re)loaded. A change to
// sample_period therefore always takes effect at the next interval boundary.
// It never changes an interval that is already running.
//
// Configuration macro:
//   SAMPLE_RETRIGGER_EN - when defined, a trigger with a non-zero length
//                         restarts playback even while busy. This includes
//                         the final-expiry cycle, and the done pulse for the
//                         aborted run is suppressed. When undefined, a
//                         trigger that arrives while busy is ignored.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-low reset
//   sample_period  in   cycles per sample, floored at MIN_PERIOD on each load
//   trigger        in   single-cycle start pulse
//   sample_len     in   number of samples, latched on an accepted trigger
//   addr           out  current sample read address
//   addr_valid     out  one-cycle strobe: addr is newly valid
//   busy           out  high while playing
//   done           out  one-cycle pulse when the final interval expires
// ============================================================================
module sample_step_timer #(
    parameter int ADDR_W     = 16,
    parameter int PERIOD_W   = 14,
    parameter int MIN_PERIOD = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PERIOD_W-1:0] sample_period,
    input  logic                trigger,
    input  logic [ADDR_W-1:0]   sample_len,
    output logic [ADDR_W-1:0]   addr,
    output logic                addr_valid,
    output logic                busy,
    output logic                done
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_PLAY = 1'b1;

    localparam logic [PERIOD_W-1:0] MinPeriod = PERIOD_W'(MIN_PERIOD);

    logic                state_q, state_d;
    logic [PERIOD_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    logic [PERIOD_W-1:0] periodFloor;
    logic [PERIOD_W-1:0] reloadVal;
    logic                canStart;
    logic                startPlay;
    logic                intervalEnd;
    logic                lastSample;

    // Floor the period, then load the countdown with P-1. This makes the
    // interval last exactly P cycles, counting the cycle that holds zero.
    assign periodFloor = (sample_period < MinPeriod) ? MinPeriod : sample_period;
    assign reloadVal   = periodFloor - PERIOD_W'(1);

`ifdef SAMPLE_RETRIGGER_EN
    assign canStart = 1'b1;
`else
    assign canStart = (state_q == STATE_IDLE);
`endif

    assign startPlay   = trigger && (sample_len != '0) && canStart;
    assign intervalEnd = (state_q == STATE_PLAY) && (count_q == '0);
    assign lastSample  = (addr_q == (len_q - ADDR_W'(1)));

    // Next-state logic. A start has priority over interval expiry, so a
    // retrigger in the final-expiry cycle restarts playback and no done
    // pulse is produced.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        len_d   = len_q;
        valid_d = 1'b0;
        done_d  = 1'b0;

        if (startPlay) begin
            state_d = STATE_PLAY;
            len_d   = sample_len;
            addr_d  = '0;
            valid_d = 1'b1;
            count_d = reloadVal;
        end else if (intervalEnd) begin
            if (lastSample) begin
                // addr keeps its last value after playback finishes.
                state_d = STATE_IDLE;
                done_d  = 1'b1;
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                valid_d = 1'b1;
                count_d = reloadVal;
            end
        end else if (state_q == STATE_PLAY) begin
            count_d = count_q - PERIOD_W'(1);
        end
    end

    // State registers. Reset takes effect immediately, even mid-playback,
    // and it never produces a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= STATE_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign addr       = addr_q;
    assign addr_valid = valid_q;
    assign busy       = (state_q == STATE_PLAY);
    assign done       = done_q;

endmodule

// File: tb/tb_sample_step_timer.sv
// ============================================================================
// tb_sample_step_timer
//
// Self-checking bench for sample_step_timer. A reference model tracks each
// playback as an absolute schedule: the cycle of the next strobe or done
// event, plus the current address. The bench compares the model against the
// DUT every cycle. It also checks directed timestamps against the
// hand-derived values of the key scenarios.
// Honours SAMPLE_RETRIGGER_EN in the same way as the design.
// ============================================================================
module tb_sample_step_timer;

    localparam int ADDR_W     = 16;
    localparam int PERIOD_W   = 14;
    localparam int MIN_PERIOD = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [PERIOD_W-1:0] sample_period = '0;
    logic                trigger = 1'b0;
    logic [ADDR_W-1:0]   sample_len = '0;
    logic [ADDR_W-1:0]   addr;
    logic                addr_valid;
    logic                busy;
    logic                done;

    sample_step_timer #(
        .ADDR_W    (ADDR_W),
        .PERIOD_W  (PERIOD_W),
        .MIN_PERIOD(MIN_PERIOD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_period(sample_period),
        .trigger      (trigger),
        .sample_len   (sample_len),
        .addr         (addr),
        .addr_valid   (addr_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int checksTotal  = 0;
    int checksPassed = 0;
    int cycleNum     = 0;

    // Reference model: playback described by absolute event times.
    bit mPlaying   = 1'b0;
    int mAddr      = 0;
    int mLen       = 0;
    int mNextEvent = 0;
    bit mValid     = 1'b0;
    bit mDone      = 1'b0;

    // Event log used by the directed timestamp checks.
    int strobeCycles[$];
    int doneCycle = -1;
    int doneCount = 0;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checksTotal++;
        if (observed == expected) checksPassed++;
        else $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)",
                      tag, observed, expected, cycleNum);
    endtask

    function automatic int floorPeriod(input int p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    // Consumes the inputs of the current cycle. Produces the expected
    // outputs of the following cycle.
    task automatic modelStep();
        bit accept;
        accept = trigger && (sample_len != 0);
`ifndef SAMPLE_RETRIGGER_EN
        if (mPlaying) accept = 1'b0;
`endif
        mValid = 1'b0;
        mDone  = 1'b0;
        if (accept) begin
            mPlaying   = 1'b1;
            mLen       = int'(sample_len);
            mAddr      = 0;
            mValid     = 1'b1;
            mNextEvent = cycleNum + 1 + floorPeriod(int'(sample_period));
        end else if (mPlaying && (cycleNum + 1 == mNextEvent)) begin
            if (mAddr + 1 < mLen) begin
                mAddr++;
                mValid     = 1'b1;
                mNextEvent = cycleNum + 1 + floorPeriod(int'(sample_period));
            end else begin
                mDone    = 1'b1;
                mPlaying = 1'b0;
            end
        end
    endtask

    task automatic modelReset();
        mPlaying = 1'b0;
        mAddr    = 0;
        mLen     = 0;
        mValid   = 1'b0;
        mDone    = 1'b0;
    endtask

    task automatic clearLog();
        strobeCycles.delete();
        doneCycle = -1;
        doneCount = 0;
    endtask

    function automatic int strobeOffset(input int k, input int t);
        return (strobeCycles.size() > k) ? strobeCycles[k] - t : -1;
    endfunction

    // Advance one clock cycle and compare every output with the model.
    task automatic stepCycle();
        modelStep();
        @(posedge clk);
        #1;
        cycleNum++;
        checkOutput("addr", addr, mAddr);
        checkOutput("addr_valid", addr_valid, mValid);
        checkOutput("busy", busy, mPlaying);
        checkOutput("done", done, mDone);
        if (addr_valid) strobeCycles.push_back(cycleNum);
        if (done) begin
            doneCycle = cycleNum;
            doneCount++;
        end
    endtask

    task automatic applyStimulus(input bit trig, input int period, input int len, output int tCycle);
        trigger       = trig;
        sample_period = PERIOD_W'(period);
        sample_len    = ADDR_W'(len);
        tCycle        = cycleNum;
        stepCycle();
        trigger = 1'b0;
    endtask

    task automatic stepUntil(input int target);
        while (cycleNum < target) stepCycle();
    endtask

    task automatic runUntilIdle(input int limit);
        int n;
        n = 0;
        while ((mPlaying || busy) && n < limit) begin
            stepCycle();
            n++;
        end
        if (n >= limit) checkOutput("runTimeout", n, 0);
        stepCycle();
        stepCycle();
    endtask

    initial begin
        int t;
        int t2;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstAddr", addr, 0);
        checkOutput("rstValid", addr_valid, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        rst = 1'b1;
        modelReset();
        repeat (3) stepCycle();

        // Basic run.
        clearLog();
        applyStimulus(1'b1, 568, 3, t);
        runUntilIdle(5000);
        checkOutput("basicS0", strobeOffset(0, t), 1);
        checkOutput("basicS1", strobeOffset(1, t), 569);
        checkOutput("basicS2", strobeOffset(2, t), 1137);
        checkOutput("basicDone", doneCycle - t, 1705);

        // Mid-interval period change.
        clearLog();
        applyStimulus(1'b1, 2272, 3, t);
        stepUntil(t + 100);
        sample_period = PERIOD_W'(1136);
        runUntilIdle(10000);
        checkOutput("midS1", strobeOffset(1, t), 2273);
        checkOutput("midS2", strobeOffset(2, t), 3409);
        checkOutput("midDone", doneCycle - t, 4545);

        // Period clamp.
        clearLog();
        applyStimulus(1'b1, 0, 4, t);
        runUntilIdle(100);
        checkOutput("clampS1", strobeOffset(1, t), 3);
        checkOutput("clampS3", strobeOffset(3, t), 7);
        checkOutput("clampDone", doneCycle - t, 9);

        // Zero-length trigger is ignored.
        clearLog();
        applyStimulus(1'b1, 100, 0, t);
        repeat (19) stepCycle();
        checkOutput("len0Strobes", strobeCycles.size(), 0);
        checkOutput("len0Done", doneCount, 0);

        // Trigger while busy.
        clearLog();
        applyStimulus(1'b1, 568, 5, t);
        stepUntil(t + 600);
        applyStimulus(1'b1, 568, 2, t2);
        runUntilIdle(5000);
`ifdef SAMPLE_RETRIGGER_EN
        checkOutput("retrigS2", strobeOffset(2, t), 601);
        checkOutput("retrigS3", strobeOffset(3, t), 1169);
        checkOutput("retrigDone", doneCycle - t, 1737);
`else
        checkOutput("retrigS4", strobeOffset(4, t), 2273);
        checkOutput("retrigDone", doneCycle - t, 2841);
`endif
        checkOutput("retrigDoneCount", doneCount, 1);

        // Trigger in the final-expiry cycle.
        clearLog();
        applyStimulus(1'b1, 3, 1, t);
        stepUntil(t + 3);
        applyStimulus(1'b1, 3, 2, t2);
        runUntilIdle(100);
`ifdef SAMPLE_RETRIGGER_EN
        checkOutput("finalRetrigS1", strobeOffset(1, t), 4);
        checkOutput("finalRetrigDone", doneCycle - t, 10);
`else
        checkOutput("finalRetrigStrobes", strobeCycles.size(), 1);
        checkOutput("finalRetrigDone", doneCycle - t, 4);
`endif
        checkOutput("finalRetrigDoneCount", doneCount, 1);

        // Asynchronous reset in the middle of playback.
        clearLog();
        applyStimulus(1'b1, 568, 5, t);
        stepUntil(t + 700);
        checkOutput("preRstBusy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("asyncAddr", addr, 0);
        checkOutput("asyncValid", addr_valid, 0);
        checkOutput("asyncBusy", busy, 0);
        checkOutput("asyncDone", done, 0);
        modelReset();
        #2;
        rst = 1'b1;
        clearLog();
        repeat (20) stepCycle();
        checkOutput("postRstStrobes", strobeCycles.size(), 0);
        checkOutput("postRstDone", doneCount, 0);

        // Randomized traffic: period changes, short lengths, sporadic triggers.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 20) sample_period = PERIOD_W'($urandom_range(0, 12));
            sample_len = ADDR_W'($urandom_range(0, 5));
            trigger    = ($urandom_range(0, 99) < 4);
            stepCycle();
            trigger = 1'b0;
        end
        runUntilIdle(10000);

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
